// File: rtl/ex_muldiv_stage_pkg.sv
// Shared definitions for the execute stage: datapath widths, ALU opcode
// encodings, the multiply/divide FSM state type and opcode classifiers.
package ex_muldiv_stage_pkg;

    localparam int NB_BITS    = 32;
    localparam int NB_CTR_MEM = 8;
    localparam int NB_CTR     = NB_CTR_MEM >> 1;
    localparam int NB_OP      = 5;
    localparam int NB_REG     = 5;
    localparam int NB_CTR_WB  = 2;
    localparam int NB_CNT     = $clog2(NB_BITS);

    typedef enum logic [NB_OP-1:0] {
        OP_ADD   = 5'd0,
        OP_SUB   = 5'd1,
        OP_AND   = 5'd2,
        OP_OR    = 5'd3,
        OP_XOR   = 5'd4,
        OP_NOR   = 5'd5,
        OP_SLT   = 5'd6,
        OP_SLTU  = 5'd7,
        OP_SLL   = 5'd8,
        OP_SRL   = 5'd9,
        OP_SRA   = 5'd10,
        OP_SLLV  = 5'd11,
        OP_SRLV  = 5'd12,
        OP_SRAV  = 5'd13,
        OP_LUI   = 5'd14,
        OP_MULT  = 5'd15,
        OP_MULTU = 5'd16,
        OP_DIV   = 5'd17,
        OP_DIVU  = 5'd18,
        OP_MFHI  = 5'd19,
        OP_MFLO  = 5'd20,
        OP_MTHI  = 5'd21,
        OP_MTLO  = 5'd22
    } alu_op_e;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

    // Ops that touch HI/LO and therefore must wait for the iterative unit.
    function automatic logic is_hazard_op(input logic [NB_OP-1:0] op);
        return op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU,
                          OP_MFHI, OP_MFLO, OP_MTHI, OP_MTLO};
    endfunction

    function automatic logic is_muldiv_op(input logic [NB_OP-1:0] op);
        return op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};
    endfunction

endpackage

// File: rtl/ex_muldiv_stage_if.sv
// ID/EX -> EX -> EX/MEM signal bundle for the execute stage.
//   i_*  : instruction and operands coming from ID/EX
//   o_*  : EX/MEM latch contents plus the stall/busy status
// master = decode side (drives i_*), slave = execute stage (drives o_*).
interface ex_muldiv_stage_if;
    import ex_muldiv_stage_pkg::*;

    logic                 i_valid;
    logic [NB_OP-1:0]     i_alu_op;
    logic [NB_BITS-1:0]   i_op_a;
    logic [NB_BITS-1:0]   i_op_b;
    logic [4:0]           i_shamt;
    logic [NB_BITS-1:0]   i_store_data;
    logic [NB_CTR-1:0]    i_write_ctl;
    logic [NB_CTR-1:0]    i_read_ctl;
    logic [NB_REG-1:0]    i_reg_dst;
    logic [NB_CTR_WB-1:0] i_wb_ctl;

    logic [NB_BITS-1:0]   o_addr;
    logic [NB_BITS-1:0]   o_data;
    logic [NB_CTR-1:0]    o_write_ctl;
    logic [NB_CTR-1:0]    o_read_ctl;
    logic [NB_REG-1:0]    o_reg_dst;
    logic [NB_CTR_WB-1:0] o_wb_ctl;
    logic                 o_stall;
    logic                 o_busy;

    modport master (
        output i_valid, i_alu_op, i_op_a, i_op_b, i_shamt, i_store_data,
               i_write_ctl, i_read_ctl, i_reg_dst, i_wb_ctl,
        input  o_addr, o_data, o_write_ctl, o_read_ctl, o_reg_dst, o_wb_ctl,
               o_stall, o_busy
    );

    modport slave (
        input  i_valid, i_alu_op, i_op_a, i_op_b, i_shamt, i_store_data,
               i_write_ctl, i_read_ctl, i_reg_dst, i_wb_ctl,
        output o_addr, o_data, o_write_ctl, o_read_ctl, o_reg_dst, o_wb_ctl,
               o_stall, o_busy
    );

endinterface

// File: rtl/ex_muldiv_stage_muldiv_iter.sv
// Iterative multiply/divide unit with the HI/LO registers.
//   i_start      : accepted MULT/MULTU/DIV/DIVU (only honoured in IDLE)
//   i_op         : opcode of the starting op (selects mul/div, signedness)
//   i_op_a/b     : rs/rt operands; i_op_a is also the MTHI/MTLO source
//   i_mthi/mtlo  : accepted register moves into HI/LO
//   o_idle       : unit can accept a HI/LO op this cycle
//   o_busy       : iteration in progress
//   o_hi/o_lo    : architectural HI/LO
//
// state   | meaning
// --------+---------------------------------------------------------
// MD_IDLE | waiting; MTHI/MTLO write HI/LO directly
// MD_BUSY | one shift-add or restoring-subtract step per cycle
// MD_DONE | sign fix applied, HI/LO written, back to IDLE
module ex_muldiv_stage_muldiv_iter
    import ex_muldiv_stage_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic [NB_OP-1:0]   i_op,
    input  logic [NB_BITS-1:0] i_op_a,
    input  logic [NB_BITS-1:0] i_op_b,
    input  logic               i_mthi,
    input  logic               i_mtlo,
    output logic               o_idle,
    output logic               o_busy,
    output logic [NB_BITS-1:0] o_hi,
    output logic [NB_BITS-1:0] o_lo
);

    md_state_e          state_q, state_d;
    logic [NB_CNT-1:0]  cnt_q, cnt_d;
    // acc: product upper half / partial remainder
    // work: multiplier shifting out / dividend shifting out, quotient in
    // opnd: multiplicand / divisor magnitude
    logic [NB_BITS-1:0] acc_q, acc_d, work_q, work_d, opnd_q, opnd_d;
    logic [NB_BITS-1:0] hi_q, hi_d, lo_q, lo_d;
    logic               is_div_q, is_div_d, neg_q, neg_d, rem_neg_q, rem_neg_d;

    logic                 start_signed, start_div, sign_a, sign_b;
    logic [NB_BITS-1:0]   mag_a, mag_b;
    logic [NB_BITS:0]     mul_sum, div_shift, div_diff;
    logic [2*NB_BITS-1:0] prod_fix;

    always_comb begin
        start_signed = (i_op == OP_MULT) || (i_op == OP_DIV);
        start_div    = (i_op == OP_DIV)  || (i_op == OP_DIVU);
        sign_a       = start_signed & i_op_a[NB_BITS-1];
        sign_b       = start_signed & i_op_b[NB_BITS-1];
        mag_a        = sign_a ? -i_op_a : i_op_a;
        mag_b        = sign_b ? -i_op_b : i_op_b;
        mul_sum      = {1'b0, acc_q} + (work_q[0] ? {1'b0, opnd_q} : '0);
        div_shift    = {acc_q, work_q[NB_BITS-1]};
        div_diff     = div_shift - {1'b0, opnd_q};
        prod_fix     = neg_q ? -{acc_q, work_q} : {acc_q, work_q};
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        work_d    = work_q;
        opnd_d    = opnd_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        is_div_d  = is_div_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        case (state_q)
            MD_IDLE: begin
                if (i_start) begin
                    state_d   = MD_BUSY;
                    cnt_d     = NB_CNT'(NB_BITS - 1);
                    acc_d     = '0;
                    is_div_d  = start_div;
                    neg_d     = sign_a ^ sign_b;
                    rem_neg_d = sign_a;
                    work_d    = start_div ? mag_a : mag_b;
                    opnd_d    = start_div ? mag_b : mag_a;
                end
                if (i_mthi) hi_d = i_op_a;
                if (i_mtlo) lo_d = i_op_a;
            end
            MD_BUSY: begin
                if (is_div_q) begin
                    // Borrow clear means the shifted remainder covers the divisor.
                    if (!div_diff[NB_BITS]) begin
                        acc_d  = div_diff[NB_BITS-1:0];
                        work_d = {work_q[NB_BITS-2:0], 1'b1};
                    end else begin
                        acc_d  = div_shift[NB_BITS-1:0];
                        work_d = {work_q[NB_BITS-2:0], 1'b0};
                    end
                end else begin
                    {acc_d, work_d} = {mul_sum, work_q[NB_BITS-1:1]};
                end
                cnt_d = cnt_q - NB_CNT'(1);
                if (cnt_q == '0) state_d = MD_DONE;
            end
            MD_DONE: begin
                if (is_div_q) begin
                    lo_d = neg_q     ? -work_q : work_q;
                    hi_d = rem_neg_q ? -acc_q  : acc_q;
                end else begin
                    hi_d = prod_fix[2*NB_BITS-1:NB_BITS];
                    lo_d = prod_fix[NB_BITS-1:0];
                end
                state_d = MD_IDLE;
            end
            default: state_d = MD_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= MD_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            work_q    <= '0;
            opnd_q    <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            work_q    <= work_d;
            opnd_q    <= opnd_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            is_div_q  <= is_div_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
        end
    end

    assign o_idle = (state_q == MD_IDLE);
    assign o_busy = (state_q != MD_IDLE);
    assign o_hi   = hi_q;
    assign o_lo   = lo_q;

endmodule

// File: rtl/ex_muldiv_stage.sv
// Execute stage: single-cycle ALU, HI/LO hazard stall and the EX/MEM latch,
// with the iterative multiply/divide unit running in the background.
//   i_clk, i_rst : clock, synchronous active-high reset
//   bus          : slave side of ex_muldiv_stage_if (ID/EX in, EX/MEM out,
//                  combinational o_stall, o_busy)
module ex_muldiv_stage
    import ex_muldiv_stage_pkg::*;
(
    input  logic                     i_clk,
    input  logic                     i_rst,
    ex_muldiv_stage_if.slave         bus
);

    logic               md_idle, md_busy;
    logic [NB_BITS-1:0] hi, lo;
    logic               hazard, stall, accept;
    logic [NB_BITS-1:0] alu_res;

    logic [NB_BITS-1:0]   addr_q, addr_d, data_q, data_d;
    logic [NB_CTR-1:0]    write_ctl_q, write_ctl_d, read_ctl_q, read_ctl_d;
    logic [NB_REG-1:0]    reg_dst_q, reg_dst_d;
    logic [NB_CTR_WB-1:0] wb_ctl_q, wb_ctl_d;

    always_comb begin
        hazard = is_hazard_op(bus.i_alu_op);
        stall  = bus.i_valid & hazard & ~md_idle;
        accept = bus.i_valid & ~stall;
    end

    ex_muldiv_stage_muldiv_iter u_muldiv (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_start (accept & is_muldiv_op(bus.i_alu_op)),
        .i_op    (bus.i_alu_op),
        .i_op_a  (bus.i_op_a),
        .i_op_b  (bus.i_op_b),
        .i_mthi  (accept & (bus.i_alu_op == OP_MTHI)),
        .i_mtlo  (accept & (bus.i_alu_op == OP_MTLO)),
        .o_idle  (md_idle),
        .o_busy  (md_busy),
        .o_hi    (hi),
        .o_lo    (lo)
    );

    always_comb begin
        alu_res = '0;
        case (bus.i_alu_op)
            OP_ADD:  alu_res = bus.i_op_a + bus.i_op_b;
            OP_SUB:  alu_res = bus.i_op_a - bus.i_op_b;
            OP_AND:  alu_res = bus.i_op_a & bus.i_op_b;
            OP_OR:   alu_res = bus.i_op_a | bus.i_op_b;
            OP_XOR:  alu_res = bus.i_op_a ^ bus.i_op_b;
            OP_NOR:  alu_res = ~(bus.i_op_a | bus.i_op_b);
            OP_SLT:  alu_res = {{(NB_BITS-1){1'b0}}, $signed(bus.i_op_a) < $signed(bus.i_op_b)};
            OP_SLTU: alu_res = {{(NB_BITS-1){1'b0}}, bus.i_op_a < bus.i_op_b};
            OP_SLL:  alu_res = bus.i_op_b << bus.i_shamt;
            OP_SRL:  alu_res = bus.i_op_b >> bus.i_shamt;
            OP_SRA:  alu_res = $signed(bus.i_op_b) >>> bus.i_shamt;
            OP_SLLV: alu_res = bus.i_op_b << bus.i_op_a[4:0];
            OP_SRLV: alu_res = bus.i_op_b >> bus.i_op_a[4:0];
            OP_SRAV: alu_res = $signed(bus.i_op_b) >>> bus.i_op_a[4:0];
            OP_LUI:  alu_res = {bus.i_op_b[NB_BITS/2-1:0], {(NB_BITS/2){1'b0}}};
            default: alu_res = '0;
        endcase
    end

    // Anything not producing a GPR/memory result (stall, bubble, MULT*/DIV*,
    // MTHI/MTLO) loads an all-zero bubble.
    always_comb begin
        addr_d      = '0;
        data_d      = '0;
        write_ctl_d = '0;
        read_ctl_d  = '0;
        reg_dst_d   = '0;
        wb_ctl_d    = '0;
        if (accept) begin
            if (!hazard) begin
                addr_d      = alu_res;
                data_d      = bus.i_store_data;
                write_ctl_d = bus.i_write_ctl;
                read_ctl_d  = bus.i_read_ctl;
                reg_dst_d   = bus.i_reg_dst;
                wb_ctl_d    = bus.i_wb_ctl;
            end else if (bus.i_alu_op == OP_MFHI || bus.i_alu_op == OP_MFLO) begin
                addr_d    = (bus.i_alu_op == OP_MFHI) ? hi : lo;
                reg_dst_d = bus.i_reg_dst;
                wb_ctl_d  = bus.i_wb_ctl;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            addr_q      <= '0;
            data_q      <= '0;
            write_ctl_q <= '0;
            read_ctl_q  <= '0;
            reg_dst_q   <= '0;
            wb_ctl_q    <= '0;
        end else begin
            addr_q      <= addr_d;
            data_q      <= data_d;
            write_ctl_q <= write_ctl_d;
            read_ctl_q  <= read_ctl_d;
            reg_dst_q   <= reg_dst_d;
            wb_ctl_q    <= wb_ctl_d;
        end
    end

    assign bus.o_addr      = addr_q;
    assign bus.o_data      = data_q;
    assign bus.o_write_ctl = write_ctl_q;
    assign bus.o_read_ctl  = read_ctl_q;
    assign bus.o_reg_dst   = reg_dst_q;
    assign bus.o_wb_ctl    = wb_ctl_q;
    assign bus.o_stall     = stall;
    assign bus.o_busy      = md_busy;

endmodule

// File: tb/tb_ex_muldiv_stage.sv
module tb_ex_muldiv_stage;
    import ex_muldiv_stage_pkg::*;

    logic i_clk = 1'b0;
    logic i_rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    ex_muldiv_stage_if bus();

    ex_muldiv_stage dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive(input logic v, input alu_op_e op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh, input logic [31:0] sd,
                         input logic [3:0] wr, input logic [3:0] rdc,
                         input logic [4:0] dst, input logic [1:0] wb);
        bus.i_valid      = v;
        bus.i_alu_op     = op;
        bus.i_op_a       = a;
        bus.i_op_b       = b;
        bus.i_shamt      = sh;
        bus.i_store_data = sd;
        bus.i_write_ctl  = wr;
        bus.i_read_ctl   = rdc;
        bus.i_reg_dst    = dst;
        bus.i_wb_ctl     = wb;
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        drive(1'b1, OP_ADD, 32'd1, 32'd2, 5'd0, 32'h55, 4'hF, 4'hF, 5'd3, 2'd3);
        tick();
        tick();
        checks++;
        if (bus.o_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got %h want 00000000", bus.o_addr); end
        checks++;
        if (bus.o_data !== 32'h0) begin errors++; $display("FAIL reset_data got %h want 00000000", bus.o_data); end
        checks++;
        if ({bus.o_write_ctl, bus.o_read_ctl, bus.o_reg_dst, bus.o_wb_ctl} !== 15'h0) begin
            errors++; $display("FAIL reset_ctl got w%h r%h d%h wb%h want all 0",
                               bus.o_write_ctl, bus.o_read_ctl, bus.o_reg_dst, bus.o_wb_ctl);
        end
        checks++;
        if ({bus.o_busy, bus.o_stall} !== 2'b00) begin
            errors++; $display("FAIL reset_status got busy%b stall%b want 0 0", bus.o_busy, bus.o_stall);
        end
        i_rst = 1'b0;
        drive(1'b1, OP_MFHI, 32'd0, 32'd0, 5'd0, 32'd0, 4'h0, 4'h0, 5'd4, 2'd1);
        tick();
        checks++;
        if (bus.o_addr !== 32'h0 || bus.o_reg_dst !== 5'd4) begin
            errors++; $display("FAIL reset_hi got %h/%0d want 00000000/4", bus.o_addr, bus.o_reg_dst);
        end
    endtask

    task automatic test_add_wrap();
        drive(1'b1, OP_ADD, 32'h7FFFFFFF, 32'h1, 5'd0, 32'h0, 4'h0, 4'h0, 5'd5, 2'd3);
        tick();
        checks++;
        if (bus.o_addr !== 32'h80000000) begin errors++; $display("FAIL add_wrap_addr got %h want 80000000", bus.o_addr); end
        checks++;
        if (bus.o_wb_ctl !== 2'd3 || bus.o_reg_dst !== 5'd5) begin
            errors++; $display("FAIL add_wrap_ctl got wb%0d dst%0d want wb3 dst5", bus.o_wb_ctl, bus.o_reg_dst);
        end
    endtask

    task automatic test_store();
        drive(1'b1, OP_ADD, 32'h100, 32'h4, 5'd0, 32'hDEADBEEF, 4'hF, 4'h0, 5'd0, 2'd0);
        tick();
        checks++;
        if (bus.o_addr !== 32'h104 || bus.o_data !== 32'hDEADBEEF || bus.o_write_ctl !== 4'hF) begin
            errors++; $display("FAIL store got addr %h data %h wr %h want 00000104 DEADBEEF F",
                               bus.o_addr, bus.o_data, bus.o_write_ctl);
        end
    endtask

    task automatic test_alu_ops();
        alu_op_e     ops [10] = '{OP_SUB, OP_SLT, OP_SLTU, OP_SRA, OP_SLLV,
                                  OP_LUI, OP_NOR, OP_SRLV, OP_AND, OP_XOR};
        logic [31:0] av  [10] = '{32'd5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'h24,
                                  32'd0, 32'd0, 32'd3, 32'hF0F0, 32'hFF00};
        logic [31:0] bv  [10] = '{32'd7, 32'd1, 32'd1, 32'h80000000, 32'd1,
                                  32'h1234, 32'd0, 32'h80000000, 32'hFF00, 32'h0FF0};
        logic [4:0]  shv [10] = '{5'd0, 5'd0, 5'd0, 5'd4, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0};
        logic [31:0] ev  [10] = '{32'hFFFFFFFE, 32'd1, 32'd0, 32'hF8000000, 32'h10,
                                  32'h12340000, 32'hFFFFFFFF, 32'h10000000, 32'hF000, 32'hF0F0};
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, ops[i], av[i], bv[i], shv[i], 32'd0, 4'h0, 4'h0, 5'd1, 2'd1);
            tick();
            checks++;
            if (bus.o_addr !== ev[i]) begin
                errors++; $display("FAIL alu_%s got %h want %h", ops[i].name(), bus.o_addr, ev[i]);
            end
        end
    endtask

    task automatic test_bubble();
        drive(1'b0, OP_ADD, 32'd1, 32'd1, 5'd0, 32'h1234, 4'hF, 4'hF, 5'd7, 2'd3);
        tick();
        checks++;
        if ({bus.o_addr, bus.o_data, bus.o_write_ctl, bus.o_read_ctl, bus.o_reg_dst, bus.o_wb_ctl} !== 79'h0) begin
            errors++; $display("FAIL bubble got addr %h data %h wb %0d want all 0", bus.o_addr, bus.o_data, bus.o_wb_ctl);
        end
    endtask

    task automatic test_mult_stall();
        int n;
        drive(1'b1, OP_MULT, 32'hFFFFFFFD, 32'd7, 5'd0, 32'd0, 4'h0, 4'h0, 5'd9, 2'd3);
        tick();
        checks++;
        if ({bus.o_addr, bus.o_reg_dst, bus.o_wb_ctl} !== 39'h0 || bus.o_busy !== 1'b1) begin
            errors++; $display("FAIL mult_issue got addr %h wb %0d busy %b want 0 0 1", bus.o_addr, bus.o_wb_ctl, bus.o_busy);
        end
        drive(1'b1, OP_MFLO, 32'd0, 32'd0, 5'd0, 32'd0, 4'h0, 4'h0, 5'd8, 2'd1);
        #1;
        n = 0;
        while (bus.o_stall === 1'b1 && n < 60) begin
            n++;
            tick();
            checks++;
            if (bus.o_addr !== 32'h0 || bus.o_wb_ctl !== 2'd0) begin
                errors++; $display("FAIL mult_stall_bubble got addr %h wb %0d want 0 0", bus.o_addr, bus.o_wb_ctl);
            end
        end
        checks++;
        if (n !== 33) begin errors++; $display("FAIL mult_stall_cycles got %0d want 33", n); end
        tick();
        checks++;
        if (bus.o_addr !== 32'hFFFFFFEB || bus.o_wb_ctl !== 2'd1 || bus.o_reg_dst !== 5'd8) begin
            errors++; $display("FAIL mult_mflo got %h wb%0d dst%0d want FFFFFFEB wb1 dst8", bus.o_addr, bus.o_wb_ctl, bus.o_reg_dst);
        end
        drive(1'b1, OP_MFHI, 32'd0, 32'd0, 5'd0, 32'd0, 4'h0, 4'h0, 5'd8, 2'd1);
        tick();
        checks++;
        if (bus.o_addr !== 32'hFFFFFFFF) begin errors++; $display("FAIL mult_mfhi got %h want FFFFFFFF", bus.o_addr); end
    endtask

    task automatic test_divu_interleave();
        int n;
        drive(1'b1, OP_DIVU, 32'd100, 32'd7, 5'd0, 32'd0, 4'h0, 4'h0, 5'd0, 2'd0);
        tick();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, OP_ADD, 32'(i * 3), 32'd10, 5'd0, 32'd0, 4'h0, 4'h0, 5'(i + 1), 2'd1);
            #1;
            checks++;
            if (bus.o_stall !== 1'b0 || bus.o_busy !== 1'b1) begin
                errors++; $display("FAIL divu_add_stall got stall %b busy %b want 0 1", bus.o_stall, bus.o_busy);
            end
            tick();
            checks++;
            if (bus.o_addr !== 32'(i * 3 + 10)) begin
                errors++; $display("FAIL divu_add_result got %h want %h", bus.o_addr, 32'(i * 3 + 10));
            end
        end
        drive(1'b1, OP_MFLO, 32'd0, 32'd0, 5'd0, 32'd0, 4'h0, 4'h0, 5'd2, 2'd1);
        #1;
        n = 0;
        while (bus.o_stall === 1'b1 && n < 60) begin n++; tick(); end
        checks++;
        if (n >= 60) begin errors++; $display("FAIL divu_timeout got %0d cycles want < 60", n); end
        tick();
        checks++;
        if (bus.o_addr !== 32'd14) begin errors++; $display("FAIL divu_mflo got %h want 0000000e", bus.o_addr); end
        drive(1'b1, OP_MFHI, 32'd0, 32'd0, 5'd0, 32'd0, 4'h0, 4'h0, 5'd2, 2'd1);
        tick();
        checks++;
        if (bus.o_addr !== 32'd2) begin errors++; $display("FAIL divu_mfhi got %h want 00000002", bus.o_addr); end
    endtask

    task automatic test_div_cases();
        alu_op_e     ops [5] = '{OP_DIV, OP_DIV, OP_DIVU, OP_MULTU, OP_DIV};
        logic [31:0] av  [5] = '{32'hFFFFFFF9, 32'h80000000, 32'h1234, 32'hFFFFFFFF, 32'd7};
        logic [31:0] bv  [5] = '{32'd2, 32'hFFFFFFFF, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFE};
        logic [31:0] elo [5] = '{32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFD};
        logic [31:0] ehi [5] = '{32'hFFFFFFFF, 32'h0, 32'h1234, 32'hFFFFFFFE, 32'h1};
        int n;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, ops[i], av[i], bv[i], 5'd0, 32'd0, 4'h0, 4'h0, 5'd0, 2'd0);
            tick();
            drive(1'b1, OP_MFLO, 32'd0, 32'd0, 5'd0, 32'd0, 4'h0, 4'h0, 5'd3, 2'd1);
            #1;
            n = 0;
            while (bus.o_stall === 1'b1 && n < 60) begin n++; tick(); end
            checks++;
            if (n >= 60) begin errors++; $display("FAIL md_timeout case %0d got %0d cycles want < 60", i, n); end
            tick();
            checks++;
            if (bus.o_addr !== elo[i]) begin
                errors++; $display("FAIL md_lo case %0d %s got %h want %h", i, ops[i].name(), bus.o_addr, elo[i]);
            end
            drive(1'b1, OP_MFHI, 32'd0, 32'd0, 5'd0, 32'd0, 4'h0, 4'h0, 5'd3, 2'd1);
            tick();
            checks++;
            if (bus.o_addr !== ehi[i]) begin
                errors++; $display("FAIL md_hi case %0d %s got %h want %h", i, ops[i].name(), bus.o_addr, ehi[i]);
            end
        end
    endtask

    task automatic test_mthi_mtlo();
        drive(1'b1, OP_MTHI, 32'hAAAA5555, 32'd0, 5'd0, 32'd0, 4'h0, 4'h0, 5'd6, 2'd3);
        tick();
        checks++;
        if (bus.o_wb_ctl !== 2'd0 || bus.o_addr !== 32'h0) begin
            errors++; $display("FAIL mthi_bubble got addr %h wb %0d want 0 0", bus.o_addr, bus.o_wb_ctl);
        end
        drive(1'b1, OP_MTLO, 32'h12345678, 32'd0, 5'd0, 32'd0, 4'h0, 4'h0, 5'd6, 2'd3);
        tick();
        drive(1'b1, OP_MFHI, 32'd0, 32'd0, 5'd0, 32'd0, 4'h0, 4'h0, 5'd6, 2'd1);
        tick();
        checks++;
        if (bus.o_addr !== 32'hAAAA5555) begin errors++; $display("FAIL mthi got %h want AAAA5555", bus.o_addr); end
        drive(1'b1, OP_MFLO, 32'd0, 32'd0, 5'd0, 32'd0, 4'h0, 4'h0, 5'd6, 2'd1);
        tick();
        checks++;
        if (bus.o_addr !== 32'h12345678) begin errors++; $display("FAIL mtlo got %h want 12345678", bus.o_addr); end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, OP_MULT, 32'd5, 32'd5, 5'd0, 32'd0, 4'h0, 4'h0, 5'd0, 2'd0);
        tick();
        drive(1'b1, OP_ADD, 32'd1, 32'd1, 5'd0, 32'h77, 4'h3, 4'h0, 5'd4, 2'd2);
        for (int i = 0; i < 9; i++) tick();
        checks++;
        if (bus.o_busy !== 1'b1 || bus.o_addr !== 32'd2) begin
            errors++; $display("FAIL rstmid_pre got busy %b addr %h want 1 00000002", bus.o_busy, bus.o_addr);
        end
        i_rst = 1'b1;
        tick();
        checks++;
        if ({bus.o_addr, bus.o_data, bus.o_write_ctl, bus.o_read_ctl, bus.o_reg_dst, bus.o_wb_ctl} !== 79'h0) begin
            errors++; $display("FAIL rstmid_latch got addr %h data %h wb %0d want all 0", bus.o_addr, bus.o_data, bus.o_wb_ctl);
        end
        checks++;
        if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0", bus.o_busy); end
        i_rst = 1'b0;
        drive(1'b1, OP_MFHI, 32'd0, 32'd0, 5'd0, 32'd0, 4'h0, 4'h0, 5'd1, 2'd1);
        #1;
        checks++;
        if (bus.o_stall !== 1'b0) begin errors++; $display("FAIL rstmid_stall got %b want 0", bus.o_stall); end
        tick();
        checks++;
        if (bus.o_addr !== 32'h0) begin errors++; $display("FAIL rstmid_mfhi got %h want 00000000", bus.o_addr); end
        drive(1'b1, OP_MFLO, 32'd0, 32'd0, 5'd0, 32'd0, 4'h0, 4'h0, 5'd1, 2'd1);
        tick();
        checks++;
        if (bus.o_addr !== 32'h0) begin errors++; $display("FAIL rstmid_mflo got %h want 00000000", bus.o_addr); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        drive(1'b0, OP_ADD, 32'd0, 32'd0, 5'd0, 32'd0, 4'h0, 4'h0, 5'd0, 2'd0);
        test_reset();
        test_add_wrap();
        test_store();
        test_alu_ops();
        test_bubble();
        test_mult_stall();
        test_divu_interleave();
        test_div_cases();
        test_mthi_mtlo();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
